// File: rtl/bcd_to_bin_serial.sv
// Serial 4-digit BCD to 14-bit binary converter. It uses reverse double-dabble, one shift per clock, with done 14 cycles after accept.
// Optional macro BCD_CHECK_EN rejects nibbles > 9: the block flags err and finishes one cycle after accept.
module bcd_to_bin_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bcd_in,
  output logic [13:0] bin_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state;
  logic [29:0] work;
  logic [29:0] work_nxt;
  logic [3:0]  cnt;

`ifdef BCD_CHECK_EN
  logic bad;
  logic in_bad;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end
`endif

  // Shift right, then pull each BCD nibble that is 8 or more back into range by subtracting 3
  always_comb begin
    work_nxt = {1'b0, work[29:1]};
    for (int i = 0; i < 4; i++) begin
      if (work_nxt[14 + 4*i + 3]) begin
        work_nxt[14 + 4*i +: 4] = work_nxt[14 + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef BCD_CHECK_EN
      bad     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work  <= {bcd_in, 14'b0};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
`ifdef BCD_CHECK_EN
            bad   <= in_bad;
`endif
          end
        end
        CONV: begin
`ifdef BCD_CHECK_EN
          if (bad) begin
            bad     <= 1'b0;
            bin_out <= '0;
            err     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else
`endif
          begin
            work <= work_nxt;
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd13) begin
              bin_out <= work_nxt[13:0];
              err     <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Bench for bcd_to_bin_serial: directed boundary cases plus random valid BCD values, all checked against a decimal reference model.
// Define BCD_CHECK_EN to also exercise the invalid-digit path.
module tb_bcd_to_bin_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [13:0] bin_out;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_to_bin_serial dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decimal value of a packed BCD word (reference model)
  function automatic int bcd_val(input logic [15:0] b);
    return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done is seen. lat is the number of edges after accept, or -1 on timeout.
  task automatic wait_done(input bit rnd_start, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (rnd_start) begin
        start  = 1'($urandom_range(0, 1));
        bcd_in = 16'($urandom);
      end
      step();
      if (done) begin
        lat = i;
        break;
      end
    end
    if (rnd_start) start = 1'b0;
  endtask

  task automatic convert(input string tag, input logic [15:0] val, input bit rnd_start);
    int lat;
    bcd_in = val;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(rnd_start, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'd14);
    check_eq({tag, "_bin"}, 32'(bin_out), 32'(bcd_val(val)));
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
    step();
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_done;
    logic [15:0] v;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_bin", 32'(bin_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    convert("c1234", 16'h1234, 1'b0);
    convert("c9999", 16'h9999, 1'b0);
    convert("c0000", 16'h0000, 1'b0);
    convert("c0009", 16'h0009, 1'b0);
    convert("c1000", 16'h1000, 1'b0);

    // Random valid inputs, with stray start requests while busy
    for (int k = 0; k < 24; k++) begin
      for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      repeat ($urandom_range(0, 3)) step();
      convert("rnd", v, 1'b1);
    end

    // Hold start high: back-to-back every 15 cycles, and values offered mid-conversion are dropped
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v = (k % 2 == 0) ? 16'h0042 : 16'h0777;
      bcd_in = v;
      step();
      check_eq("held_accept", 32'(busy), 32'd1);
      bcd_in = (k % 2 == 0) ? 16'h0777 : 16'h0042;
      wait_done(1'b0, lat);
      check_eq("held_lat", 32'(lat), 32'd14);
      check_eq("held_bin", 32'(bin_out), 32'(bcd_val(v)));
    end
    start = 1'b0;
    step();

    // Reset in the 7th CONV cycle aborts without a done pulse
    bcd_in = 16'h5555;
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_bin", 32'(bin_out), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    n_done = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (done) n_done++;
    end
    check_eq("abort_no_done", 32'(n_done), 32'd0);
    convert("c0001", 16'h0001, 1'b0);

    // start and rst on the same edge: reset wins
    bcd_in = 16'h0321;
    start  = 1'b1;
    rst    = 1'b1;
    step();
    start  = 1'b0;
    rst    = 1'b0;
    check_eq("rst_start_busy", 32'(busy), 32'd0);
    check_eq("rst_start_done", 32'(done), 32'd0);
    n_done = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (done || busy) n_done++;
    end
    check_eq("rst_start_idle", 32'(n_done), 32'd0);

`ifdef BCD_CHECK_EN
    for (int k = 0; k < 6; k++) begin
      if (k == 0) v = 16'h12A4;
      else begin
        v = 16'($urandom);
        v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      end
      bcd_in = v;
      start  = 1'b1;
      step();
      start  = 1'b0;
      check_eq("bad_busy", 32'(busy), 32'd1);
      step();
      check_eq("bad_done", 32'(done), 32'd1);
      check_eq("bad_err", 32'(err), 32'd1);
      check_eq("bad_bin", 32'(bin_out), 32'd0);
      check_eq("bad_busy_done", 32'(busy), 32'd0);
      step();
      check_eq("bad_done_pulse", 32'(done), 32'd0);
      check_eq("bad_err_hold", 32'(err), 32'd1);
    end
    convert("c0100", 16'h0100, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
